// File: rtl/serial_uart_receiver_if.sv
// Receive-side bundle of the serial UART: serial line and oversample tick in,
// received byte and status pulses out.
//
// Handshake: there is no ready. RX_VALID is a one-CLK pulse that marks RX_DATA
// as new, and RX_FRAME_ERROR is a one-CLK pulse that marks a dropped frame.
// The two pulses are never high together. The consumer must capture RX_DATA
// in the cycle RX_VALID is high; there is no backpressure.
interface serial_uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 UART_RX;
  logic                 BAUD_SAMPLE_TICK;
  logic [DATA_BITS-1:0] RX_DATA;
  logic                 RX_VALID;
  logic                 RX_FRAME_ERROR;
  logic                 RX_BUSY;
  logic [2:0]           dbg_state;

  // Line/tick source side (baud generator plus pads, or a testbench).
  modport master (
    output UART_RX, BAUD_SAMPLE_TICK,
    input  RX_DATA, RX_VALID, RX_FRAME_ERROR, RX_BUSY, dbg_state
  );

  // Receiver side.
  modport slave (
    input  UART_RX, BAUD_SAMPLE_TICK,
    output RX_DATA, RX_VALID, RX_FRAME_ERROR, RX_BUSY, dbg_state
  );
endinterface

// File: rtl/serial_uart_receiver.sv
// UART receive path: synchronizes the line, finds the start bit, samples each
// data bit at its centre (LSB first), checks the stop bits and reports either
// a one-cycle RX_VALID or a one-cycle RX_FRAME_ERROR.
module serial_uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input logic                  CLK,
  input logic                  RESET,
  serial_uart_receiver_if.slave rx_if
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          SIDX_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bidx_q, bidx_d;
  logic                 sidx_q, sidx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 tick;

  assign tick = rx_if.BAUD_SAMPLE_TICK;

  // State register: all flops, synchronous reset; line synchronizer resets to idle-high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      scnt_q     <= '0;
      bidx_q     <= '0;
      sidx_q     <= 1'b0;
      shreg_q    <= '0;
      ferr_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      scnt_q     <= scnt_d;
      bidx_q     <= bidx_d;
      sidx_q     <= sidx_d;
      shreg_q    <= shreg_d;
      ferr_q     <= ferr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Next-state: everything except the synchronizer and the pulses moves only on a tick.
  always_comb begin
    state_d    = state_q;
    rx_meta_d  = rx_if.UART_RX;
    rx_s_d     = rx_meta_q;
    scnt_d     = scnt_q;
    bidx_d     = bidx_q;
    sidx_d     = sidx_q;
    shreg_d    = shreg_q;
    ferr_d     = ferr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            scnt_d  = '0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          scnt_d = scnt_q + SW'(1);
          // Half a bit in: a high line means the falling edge was a glitch.
          if (scnt_q == S_HALF) begin
            if (rx_s_q) begin
              state_d = ST_IDLE;
            end else begin
              scnt_d  = '0;
              bidx_d  = '0;
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          scnt_d = scnt_q + SW'(1);
          if (scnt_q == S_LAST) begin
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            scnt_d  = '0;
            bidx_d  = bidx_q + BW'(1);
            if (bidx_q == B_LAST) begin
              sidx_d  = 1'b0;
              ferr_d  = 1'b0;
              state_d = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          scnt_d = scnt_q + SW'(1);
          if (scnt_q == S_LAST) begin
            ferr_d = ferr_q | ~rx_s_q;
            scnt_d = '0;
            sidx_d = sidx_q + 1'b1;
            if (sidx_q == SIDX_LAST) begin
              if (!ferr_d) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
                state_d    = ST_IDLE;
              end else begin
                rx_ferr_d = 1'b1;
                state_d   = ST_BREAK;
              end
            end
          end
        end
        ST_BREAK: begin
          // A held-low line must go high before a new start can be hunted.
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: registered byte and pulses, busy and debug state from the state register.
  always_comb begin
    rx_if.RX_DATA        = rx_data_q;
    rx_if.RX_VALID       = rx_valid_q;
    rx_if.RX_FRAME_ERROR = rx_ferr_q;
    rx_if.RX_BUSY        = (state_q != ST_IDLE);
    rx_if.dbg_state      = state_q;
  end

endmodule

// File: tb/tb_serial_uart_receiver.sv
// Directed bench for the UART receiver: one 1-stop-bit instance and one
// 2-stop-bit instance, tick every 4 CLK (bit period 64 CLK nominal).
module tb_serial_uart_receiver;

  logic CLK = 1'b0;
  logic RESET;
  logic [1:0] tick_div = 2'd0;

  int errors = 0;
  int checks = 0;
  int valid_cnt0 = 0, ferr_cnt0 = 0;
  int valid_cnt1 = 0, ferr_cnt1 = 0;
  int both_cnt = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp0, exp1;

  serial_uart_receiver_if #(.DATA_BITS(8)) if0 ();
  serial_uart_receiver_if #(.DATA_BITS(8)) if1 ();

  serial_uart_receiver #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .rx_if(if0.slave)
  );
  serial_uart_receiver #(.DATA_BITS(8), .STOP_BITS(2), .OVERSAMPLE(16)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .rx_if(if1.slave)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  // Oversample tick: one CLK high out of every four
  always @(negedge CLK) begin
    tick_div = tick_div + 2'd1;
    if0.BAUD_SAMPLE_TICK = (tick_div == 2'd0);
    if1.BAUD_SAMPLE_TICK = (tick_div == 2'd0);
  end

  // Scoreboard: every RX_VALID cycle must match the next expected byte
  always @(negedge CLK) begin
    if (!RESET) begin
      if (if0.RX_VALID) begin
        valid_cnt0++;
        checks++;
        if (exp_q0.size() == 0) begin
          errors++;
          $display("FAIL rx0_unexpected_valid got=%02h expected=none", if0.RX_DATA);
        end else begin
          exp0 = exp_q0.pop_front();
          if (if0.RX_DATA !== exp0) begin
            errors++;
            $display("FAIL rx0_data got=%02h expected=%02h", if0.RX_DATA, exp0);
          end
        end
      end
      if (if1.RX_VALID) begin
        valid_cnt1++;
        checks++;
        if (exp_q1.size() == 0) begin
          errors++;
          $display("FAIL rx1_unexpected_valid got=%02h expected=none", if1.RX_DATA);
        end else begin
          exp1 = exp_q1.pop_front();
          if (if1.RX_DATA !== exp1) begin
            errors++;
            $display("FAIL rx1_data got=%02h expected=%02h", if1.RX_DATA, exp1);
          end
        end
      end
      if (if0.RX_FRAME_ERROR) ferr_cnt0++;
      if (if1.RX_FRAME_ERROR) ferr_cnt1++;
      if ((if0.RX_VALID && if0.RX_FRAME_ERROR) || (if1.RX_VALID && if1.RX_FRAME_ERROR)) both_cnt++;
    end
  end

  // Driver: hold one line at a level for a number of CLK cycles
  task automatic drive_bit(input int sel, input logic v, input int clks);
    if (sel == 0) if0.UART_RX = v;
    else          if1.UART_RX = v;
    repeat (clks) @(negedge CLK);
  endtask

  // Driver: start bit, 8 data bits LSB first, nstop stop bits at stop_v
  task automatic send_frame(input int sel, input logic [7:0] d, input logic stop_v,
                            input int nstop, input int clks);
    drive_bit(sel, 1'b0, clks);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], clks);
    for (int i = 0; i < nstop; i++) drive_bit(sel, stop_v, clks);
  endtask

  task automatic clear_counts();
    valid_cnt0 = 0; ferr_cnt0 = 0;
    valid_cnt1 = 0; ferr_cnt1 = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if (if0.RX_DATA !== 8'h00) begin errors++; $display("FAIL reset_data got=%02h expected=00", if0.RX_DATA); end
    checks++; if (if0.RX_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b expected=0", if0.RX_VALID); end
    checks++; if (if0.RX_FRAME_ERROR !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b expected=0", if0.RX_FRAME_ERROR); end
    checks++; if (if0.RX_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", if0.RX_BUSY); end
    checks++; if (if0.dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d expected=0", if0.dbg_state); end
    checks++; if (if1.RX_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b expected=0", if1.RX_BUSY); end
  endtask

  task automatic test_single();
    clear_counts();
    exp_q0.push_back(8'h55);
    send_frame(0, 8'h55, 1'b1, 1, 64);
    drive_bit(0, 1'b1, 64);
    checks++; if (valid_cnt0 !== 1) begin errors++; $display("FAIL single_valid_count got=%0d expected=1", valid_cnt0); end
    checks++; if (ferr_cnt0 !== 0) begin errors++; $display("FAIL single_ferr_count got=%0d expected=0", ferr_cnt0); end
    checks++; if (if0.RX_DATA !== 8'h55) begin errors++; $display("FAIL single_data_hold got=%02h expected=55", if0.RX_DATA); end
    checks++; if (if0.RX_BUSY !== 1'b0) begin errors++; $display("FAIL single_busy got=%b expected=0", if0.RX_BUSY); end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    exp_q0.push_back(8'h00);
    exp_q0.push_back(8'hFF);
    exp_q0.push_back(8'hA3);
    send_frame(0, 8'h00, 1'b1, 1, 64);
    send_frame(0, 8'hFF, 1'b1, 1, 64);
    send_frame(0, 8'hA3, 1'b1, 1, 64);
    drive_bit(0, 1'b1, 64);
    checks++; if (valid_cnt0 !== 3) begin errors++; $display("FAIL b2b_valid_count got=%0d expected=3", valid_cnt0); end
    checks++; if (exp_q0.size() !== 0) begin errors++; $display("FAIL b2b_pending got=%0d expected=0", exp_q0.size()); end
    checks++; if (ferr_cnt0 !== 0) begin errors++; $display("FAIL b2b_ferr_count got=%0d expected=0", ferr_cnt0); end
    checks++; if (if0.RX_DATA !== 8'hA3) begin errors++; $display("FAIL b2b_data_hold got=%02h expected=a3", if0.RX_DATA); end
  endtask

  task automatic test_glitch();
    clear_counts();
    drive_bit(0, 1'b0, 20);
    drive_bit(0, 1'b1, 32);
    checks++; if (if0.RX_BUSY !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b expected=0", if0.RX_BUSY); end
    checks++; if (valid_cnt0 !== 0) begin errors++; $display("FAIL glitch_valid_count got=%0d expected=0", valid_cnt0); end
    checks++; if (ferr_cnt0 !== 0) begin errors++; $display("FAIL glitch_ferr_count got=%0d expected=0", ferr_cnt0); end
    drive_bit(0, 1'b1, 32);
    exp_q0.push_back(8'h3C);
    send_frame(0, 8'h3C, 1'b1, 1, 64);
    drive_bit(0, 1'b1, 64);
    checks++; if (valid_cnt0 !== 1) begin errors++; $display("FAIL glitch_next_valid_count got=%0d expected=1", valid_cnt0); end
    checks++; if (if0.RX_DATA !== 8'h3C) begin errors++; $display("FAIL glitch_next_data got=%02h expected=3c", if0.RX_DATA); end
  endtask

  task automatic test_frame_error();
    clear_counts();
    send_frame(0, 8'h81, 1'b0, 1, 64);
    drive_bit(0, 1'b0, 160);
    checks++; if (ferr_cnt0 !== 1) begin errors++; $display("FAIL ferr_count got=%0d expected=1", ferr_cnt0); end
    checks++; if (valid_cnt0 !== 0) begin errors++; $display("FAIL ferr_valid_count got=%0d expected=0", valid_cnt0); end
    checks++; if (if0.RX_DATA !== 8'h3C) begin errors++; $display("FAIL ferr_data_kept got=%02h expected=3c", if0.RX_DATA); end
    checks++; if (if0.RX_BUSY !== 1'b1) begin errors++; $display("FAIL ferr_busy_low_line got=%b expected=1", if0.RX_BUSY); end
    drive_bit(0, 1'b1, 24);
    checks++; if (if0.RX_BUSY !== 1'b0) begin errors++; $display("FAIL ferr_busy_released got=%b expected=0", if0.RX_BUSY); end
    checks++; if (ferr_cnt0 !== 1) begin errors++; $display("FAIL ferr_no_retrigger got=%0d expected=1", ferr_cnt0); end
    drive_bit(0, 1'b1, 40);
  endtask

  task automatic test_mid_reset();
    clear_counts();
    // Start bit and first four data bits of 0xC7 (1,1,1,0 LSB first)
    drive_bit(0, 1'b0, 64);
    drive_bit(0, 1'b1, 64);
    drive_bit(0, 1'b1, 64);
    drive_bit(0, 1'b1, 64);
    drive_bit(0, 1'b0, 64);
    checks++; if (if0.RX_BUSY !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b expected=1", if0.RX_BUSY); end
    RESET = 1'b1;
    if0.UART_RX = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    checks++; if (if0.RX_DATA !== 8'h00) begin errors++; $display("FAIL midrst_data got=%02h expected=00", if0.RX_DATA); end
    checks++; if (if0.RX_BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b expected=0", if0.RX_BUSY); end
    checks++; if (if0.RX_VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b expected=0", if0.RX_VALID); end
    checks++; if (if0.RX_FRAME_ERROR !== 1'b0) begin errors++; $display("FAIL midrst_ferr got=%b expected=0", if0.RX_FRAME_ERROR); end
    drive_bit(0, 1'b1, 64);
    checks++; if (valid_cnt0 + ferr_cnt0 !== 0) begin errors++; $display("FAIL midrst_pulses got=%0d expected=0", valid_cnt0 + ferr_cnt0); end
    exp_q0.push_back(8'h12);
    send_frame(0, 8'h12, 1'b1, 1, 64);
    drive_bit(0, 1'b1, 64);
    checks++; if (valid_cnt0 !== 1) begin errors++; $display("FAIL midrst_next_valid got=%0d expected=1", valid_cnt0); end
    checks++; if (if0.RX_DATA !== 8'h12) begin errors++; $display("FAIL midrst_next_data got=%02h expected=12", if0.RX_DATA); end
  endtask

  task automatic test_baud_tolerance();
    // +3% baud: 62 CLK per bit; -3% baud: 66 CLK per bit
    clear_counts();
    exp_q0.push_back(8'h6B);
    send_frame(0, 8'h6B, 1'b1, 1, 62);
    drive_bit(0, 1'b1, 62);
    checks++; if (valid_cnt0 !== 1) begin errors++; $display("FAIL fast_valid_count got=%0d expected=1", valid_cnt0); end
    exp_q0.push_back(8'h6B);
    send_frame(0, 8'h6B, 1'b1, 1, 66);
    drive_bit(0, 1'b1, 66);
    checks++; if (valid_cnt0 !== 2) begin errors++; $display("FAIL slow_valid_count got=%0d expected=2", valid_cnt0); end
    checks++; if (ferr_cnt0 !== 0) begin errors++; $display("FAIL baud_ferr_count got=%0d expected=0", ferr_cnt0); end
  endtask

  task automatic test_two_stop_bits();
    clear_counts();
    exp_q1.push_back(8'h6B);
    send_frame(1, 8'h6B, 1'b1, 2, 62);
    drive_bit(1, 1'b1, 62);
    exp_q1.push_back(8'h6B);
    send_frame(1, 8'h6B, 1'b1, 2, 66);
    drive_bit(1, 1'b1, 66);
    checks++; if (valid_cnt1 !== 2) begin errors++; $display("FAIL stop2_valid_count got=%0d expected=2", valid_cnt1); end
    checks++; if (if1.RX_DATA !== 8'h6B) begin errors++; $display("FAIL stop2_data got=%02h expected=6b", if1.RX_DATA); end
    // First stop bit good, second stop bit low: must be a framing error
    send_frame(1, 8'h6B, 1'b1, 1, 64);
    drive_bit(1, 1'b0, 64);
    drive_bit(1, 1'b1, 96);
    checks++; if (ferr_cnt1 !== 1) begin errors++; $display("FAIL stop2_second_low got=%0d expected=1", ferr_cnt1); end
    checks++; if (valid_cnt1 !== 2) begin errors++; $display("FAIL stop2_no_valid got=%0d expected=2", valid_cnt1); end
    checks++; if (if1.RX_BUSY !== 1'b0) begin errors++; $display("FAIL stop2_busy got=%b expected=0", if1.RX_BUSY); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_and_ferr_overlap got=%0d expected=0", both_cnt); end
  endtask

  initial begin
    RESET = 1'b1;
    if0.UART_RX = 1'b1;
    if1.UART_RX = 1'b1;
    if0.BAUD_SAMPLE_TICK = 1'b0;
    if1.BAUD_SAMPLE_TICK = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_mid_reset();
    test_baud_tolerance();
    test_two_stop_bits();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
